// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter type and lock-state encoding
// for the VGA sync decoder.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int H_ACTIVE = 640;
   localparam int H_FRONT  = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BACK   = 48;
   localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

   localparam int V_ACTIVE = 480;
   localparam int V_FRONT  = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 33;
   localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX = '1;

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      LOCKED
   } state_t;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Recovered-position bus: the decoder drives it, overlay/pattern-check logic
// consumes it.
interface vga_sync_decoder_if;
   import vga_timing_pkg::*;

   cnt_t o_Col_Count;
   cnt_t o_Row_Count;
   logic o_Active;
   logic o_Frame_Start;
   logic o_Locked;
   logic o_Error;

   modport master (
      output o_Col_Count, o_Row_Count, o_Active, o_Frame_Start, o_Locked, o_Error
   );

   modport slave (
      input o_Col_Count, o_Row_Count, o_Active, o_Frame_Start, o_Locked, o_Error
   );

endinterface

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Two-flop synchroniser plus delay flop for one asynchronous sync pin; emits
// a one-cycle pulse on the assertion edge, whichever polarity the pin uses.
module sync_edge_detect #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Sync,
   output logic o_Edge
);

   localparam logic DEASSERTED = ACTIVE_LOW;

   logic r_Sync1;
   logic r_Sync2;
   logic r_Sync3;

   // NOTE: non-blocking assignments keep this a true three-stage shift; reset
   // loads the idle level so no false edge appears when reset releases.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Sync1 <= DEASSERTED;
         r_Sync2 <= DEASSERTED;
         r_Sync3 <= DEASSERTED;
      end else begin
         r_Sync1 <= i_Sync;
         r_Sync2 <= r_Sync1;
         r_Sync3 <= r_Sync2;
      end
   end

   assign o_Edge = (r_Sync2 != DEASSERTED) && (r_Sync3 == DEASSERTED);

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds column/row position from an HSync/VSync pair, validates line and
// frame lengths and reports lock, active video and frame start.
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int TOTAL_COLS      = H_TOTAL,
   parameter int TOTAL_ROWS      = V_TOTAL,
   parameter int ACTIVE_COLS     = H_ACTIVE,
   parameter int ACTIVE_ROWS     = V_ACTIVE,
   parameter int H_START         = H_SYNC + H_BACK,
   parameter int V_START         = V_SYNC + V_BACK,
   parameter bit SYNC_ACTIVE_LOW = 1'b1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic                      i_Clk,
   input  logic                      i_Reset,
   input  logic                      i_HSync,
   input  logic                      i_VSync,
   vga_sync_decoder_if.master        o_Pos
);

   localparam cnt_t       LINE_LAST  = cnt_t'(TOTAL_COLS - 1);
   localparam cnt_t       FRAME_LAST = cnt_t'(TOTAL_ROWS - 1);
   localparam cnt_t       H_BEGIN    = cnt_t'(H_START);
   localparam cnt_t       H_END      = cnt_t'(H_START + ACTIVE_COLS);
   localparam cnt_t       V_BEGIN    = cnt_t'(V_START);
   localparam cnt_t       V_END      = cnt_t'(V_START + ACTIVE_ROWS);
   localparam logic [3:0] LOCK_N     = 4'(LOCK_FRAMES);

   logic       w_H_Edge;
   logic       w_V_Edge;
   logic       w_Line_Fail;
   logic       w_Frame_Fail;
   logic       w_In_Window;
   logic [3:0] w_Good_Next;

   cnt_t       r_Col;
   cnt_t       r_Row;
   state_t     r_State;
   logic [3:0] r_Good;
   logic       r_Frame_Bad;
   logic       r_Active;
   logic       r_Frame_Start;
   logic       r_Locked;
   logic       r_Error;

   sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_h_edge (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Sync  (i_HSync),
      .o_Edge  (w_H_Edge)
   );

   sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_v_edge (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Sync  (i_VSync),
      .o_Edge  (w_V_Edge)
   );

   // A saturated column means HSync vanished, which is a bad line too.
   assign w_Line_Fail  = w_H_Edge ? (r_Col != LINE_LAST) : (r_Col == CNT_MAX);
   assign w_Frame_Fail = w_V_Edge && (r_Row != FRAME_LAST);
   assign w_In_Window  = (r_Col >= H_BEGIN) && (r_Col < H_END) &&
                         (r_Row >= V_BEGIN) && (r_Row < V_END);
   assign w_Good_Next  = r_Good + 4'd1;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Col         <= '0;
         r_Row         <= '0;
         r_Active      <= 1'b0;
         r_Frame_Start <= 1'b0;
      end else begin
         if (w_H_Edge)
            r_Col <= '0;
         else if (r_Col != CNT_MAX)
            r_Col <= r_Col + cnt_t'(1);

         if (w_V_Edge)
            r_Row <= '0;
         else if (w_H_Edge && (r_Row != CNT_MAX))
            r_Row <= r_Row + cnt_t'(1);

         r_Active      <= w_In_Window;
         r_Frame_Start <= (r_State == LOCKED) && (r_Col == H_BEGIN) && (r_Row == V_BEGIN);
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_State     <= SEARCH;
         r_Good      <= '0;
         r_Frame_Bad <= 1'b0;
         r_Locked    <= 1'b0;
         r_Error     <= 1'b0;
      end else begin
         r_Error <= 1'b0;
         unique case (r_State)
            SEARCH: begin
               if (w_V_Edge) begin
                  r_State     <= MEASURE;
                  r_Good      <= '0;
                  r_Frame_Bad <= 1'b0;
               end
            end
            MEASURE: begin
               if (w_Line_Fail) begin
                  r_Frame_Bad <= 1'b1;
                  r_State     <= SEARCH;
               end else if (w_V_Edge) begin
                  if (w_Frame_Fail) begin
                     r_State <= SEARCH;
                  end else if (!r_Frame_Bad) begin
                     r_Good <= w_Good_Next;
                     if (w_Good_Next == LOCK_N) begin
                        r_State  <= LOCKED;
                        r_Locked <= 1'b1;
                     end
                  end
               end
            end
            LOCKED: begin
               if (w_Line_Fail || w_Frame_Fail) begin
                  r_Error  <= 1'b1;
                  r_Locked <= 1'b0;
                  r_State  <= SEARCH;
               end
            end
            default: r_State <= SEARCH;
         endcase
      end
   end

   assign o_Pos.o_Col_Count   = r_Col;
   assign o_Pos.o_Row_Count   = r_Row;
   assign o_Pos.o_Active      = r_Active;
   assign o_Pos.o_Frame_Start = r_Frame_Start;
   assign o_Pos.o_Locked      = r_Locked;
   assign o_Pos.o_Error       = r_Error;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench: scaled-down timing, an active-low and an active-high
// decoder fed the same stream, compared every cycle against a reference model.
module tb_vga_sync_decoder;
   import vga_timing_pkg::*;

   localparam int TC  = 40;
   localparam int TR  = 20;
   localparam int AC  = 24;
   localparam int AR  = 12;
   localparam int HS  = 10;
   localparam int VS  = 4;
   localparam int LF  = 2;
   localparam int HSW = 4;
   localparam int VSW = 2;
   localparam int SAT = 1023;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic h_on  = 1'b0;
   logic v_on  = 1'b0;
   logic hs_n;
   logic vs_n;

   assign hs_n = ~h_on;
   assign vs_n = ~v_on;

   always #20 clk = ~clk;

   vga_sync_decoder_if pos_lo ();
   vga_sync_decoder_if pos_hi ();

   vga_sync_decoder #(
      .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
      .H_START(HS), .V_START(VS), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(LF)
   ) dut_lo (
      .i_Clk(clk), .i_Reset(rst), .i_HSync(hs_n), .i_VSync(vs_n), .o_Pos(pos_lo)
   );

   vga_sync_decoder #(
      .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
      .H_START(HS), .V_START(VS), .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(LF)
   ) dut_hi (
      .i_Clk(clk), .i_Reset(rst), .i_HSync(h_on), .i_VSync(v_on), .o_Pos(pos_hi)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int err_pulses, fs_pulses, act_cycles;

   // Reference model: pin history (index 0 = newest sample) and behaviour.
   bit q_h[4];
   bit q_v[4];
   int m_col, m_row, m_good;
   bit m_locked, m_measuring, m_active, m_fs, m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack_out(cnt_t c, cnt_t r, logic a, logic f, logic l, logic e);
      return {8'd0, c, r, a, f, l, e};
   endfunction

   task automatic model_step(input bit r, input bit h, input bit v);
      bit he, ve, line_fail, frame_fail;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            q_h[i] = 1'b0;
            q_v[i] = 1'b0;
         end
         m_col = 0; m_row = 0; m_good = 0;
         m_locked = 0; m_measuring = 0; m_active = 0; m_fs = 0; m_err = 0;
         return;
      end
      for (int i = 3; i > 0; i--) begin
         q_h[i] = q_h[i-1];
         q_v[i] = q_v[i-1];
      end
      q_h[0] = h;
      q_v[0] = v;
      // A pin change reaches the counters two clocks after it is sampled.
      he = q_h[2] && !q_h[3];
      ve = q_v[2] && !q_v[3];
      line_fail  = he ? (m_col != TC - 1) : (m_col == SAT);
      frame_fail = ve && (m_row != TR - 1);
      m_active = (m_col >= HS) && (m_col < HS + AC) && (m_row >= VS) && (m_row < VS + AR);
      m_fs     = m_locked && (m_col == HS) && (m_row == VS);
      m_err    = 1'b0;
      if (m_locked) begin
         if (line_fail || frame_fail) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
         end
      end else if (m_measuring) begin
         if (line_fail) begin
            m_measuring = 1'b0;
         end else if (ve) begin
            if (frame_fail) begin
               m_measuring = 1'b0;
            end else begin
               m_good++;
               if (m_good == LF) begin
                  m_locked    = 1'b1;
                  m_measuring = 1'b0;
               end
            end
         end
      end else if (ve) begin
         m_measuring = 1'b1;
         m_good      = 0;
      end
      if (ve)      m_row = 0;
      else if (he) m_row = (m_row < SAT) ? m_row + 1 : SAT;
      m_col = he ? 0 : ((m_col < SAT) ? m_col + 1 : SAT);
   endtask

   // One pixel clock: drive pins, let the DUTs and model advance, compare.
   task automatic step(input bit h, input bit v, input bit r);
      logic [31:0] exp_v;
      h_on = h;
      v_on = v;
      rst  = r;
      @(posedge clk);
      model_step(r, h, v);
      @(negedge clk);
      cyc++;
      exp_v = pack_out(cnt_t'(m_col), cnt_t'(m_row), m_active, m_fs, m_locked, m_err);
      check($sformatf("cyc%0d_lo", cyc), pack_out(pos_lo.o_Col_Count, pos_lo.o_Row_Count,
            pos_lo.o_Active, pos_lo.o_Frame_Start, pos_lo.o_Locked, pos_lo.o_Error), exp_v);
      check($sformatf("cyc%0d_hi", cyc), pack_out(pos_hi.o_Col_Count, pos_hi.o_Row_Count,
            pos_hi.o_Active, pos_hi.o_Frame_Start, pos_hi.o_Locked, pos_hi.o_Error), exp_v);
      err_pulses += int'(pos_lo.o_Error);
      fs_pulses  += int'(pos_lo.o_Frame_Start);
      act_cycles += int'(pos_lo.o_Active);
   endtask

   task automatic send_line(input int len, input bit vs, input bit h_present);
      for (int c = 0; c < len; c++) step(h_present && (c < HSW), vs, 1'b0);
   endtask

   task automatic send_frame(input int rows, input int short_row);
      for (int r = 0; r < rows; r++) send_line((r == short_row) ? TC - 1 : TC, r < VSW, 1'b1);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      repeat ($urandom_range(0, 30)) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_lock(input string tag, input logic exp);
      check({tag, "_lo"}, {31'd0, pos_lo.o_Locked}, {31'd0, exp});
      check({tag, "_hi"}, {31'd0, pos_hi.o_Locked}, {31'd0, exp});
   endtask

   initial begin
      int rr, rc;
      @(negedge clk);

      // Nominal stream from reset.
      step(1'b0, 1'b0, 1'b1);
      check("reset_state_lo", pack_out(pos_lo.o_Col_Count, pos_lo.o_Row_Count, pos_lo.o_Active,
            pos_lo.o_Frame_Start, pos_lo.o_Locked, pos_lo.o_Error), 32'd0);
      do_reset();
      err_pulses = 0;
      send_frame(TR, -1);
      send_frame(TR, -1);
      check_lock("s1_before_3rd_v", 1'b0);
      send_frame(TR, -1);
      check_lock("s1_after_3rd_v", 1'b1);
      fs_pulses  = 0;
      act_cycles = 0;
      send_frame(TR, -1);
      check("s1_frame_start_count", fs_pulses, 1);
      check("s1_active_count", act_cycles, AC * AR);
      check("s1_no_error", err_pulses, 0);

      // One short line while locked.
      err_pulses = 0;
      send_frame(TR, $urandom_range(3, TR - 2));
      check("s2_error_once", err_pulses, 1);
      check_lock("s2_dropped", 1'b0);
      send_frame(TR, -1);
      send_frame(TR, -1);
      check_lock("s2_before_relock", 1'b0);
      send_frame(TR, -1);
      check_lock("s2_relocked", 1'b1);
      check("s2_error_total", err_pulses, 1);

      // Sync removed while locked: column saturates, single error.
      err_pulses = 0;
      repeat (1100) step(1'b0, 1'b0, 1'b0);
      check("s3_col_saturated", pos_lo.o_Col_Count, SAT);
      check("s3_error_once", err_pulses, 1);
      check_lock("s3_dropped", 1'b0);
      send_frame(TR, -1);
      send_frame(TR, -1);
      check_lock("s3_before_relock", 1'b0);
      send_frame(TR, -1);
      check_lock("s3_relocked", 1'b1);

      // Short frame while measuring: back to search, no error.
      do_reset();
      err_pulses = 0;
      send_frame(TR, -1);
      send_frame(TR - 1, -1);
      send_frame(TR, -1);
      send_frame(TR, -1);
      check_lock("s4_not_locked", 1'b0);
      send_frame(TR, -1);
      check_lock("s4_before_relock", 1'b0);
      send_frame(TR, -1);
      check_lock("s4_relocked", 1'b1);
      check("s4_no_error", err_pulses, 0);

      // Reset mid-frame while locked.
      err_pulses = 0;
      rr = $urandom_range(5, 15);
      rc = $urandom_range(0, TC - 1);
      for (int r = 0; r < rr; r++) send_line(TC, r < VSW, 1'b1);
      for (int c = 0; c < rc; c++) step(c < HSW, 1'b0, 1'b0);
      step(rc < HSW, 1'b0, 1'b1);
      check("s5_reset_outputs_lo", pack_out(pos_lo.o_Col_Count, pos_lo.o_Row_Count, pos_lo.o_Active,
            pos_lo.o_Frame_Start, pos_lo.o_Locked, pos_lo.o_Error), 32'd0);
      check("s5_reset_outputs_hi", pack_out(pos_hi.o_Col_Count, pos_hi.o_Row_Count, pos_hi.o_Active,
            pos_hi.o_Frame_Start, pos_hi.o_Locked, pos_hi.o_Error), 32'd0);
      for (int c = rc + 1; c < TC; c++) step(c < HSW, 1'b0, 1'b0);
      for (int r = rr + 1; r < TR; r++) send_line(TC, 1'b0, 1'b1);
      send_frame(TR, -1);
      send_frame(TR, -1);
      check_lock("s5_before_relock", 1'b0);
      send_frame(TR, -1);
      check_lock("s5_relocked", 1'b1);
      check("s5_no_error", err_pulses, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
